game_flow_ctrl: RTL
===================

# game_flow_ctrl

Parametrised top-level game sequencer for the sliding-puzzle design. It supports NUM_LEVELS difficulty levels, configurable draw-phase durations, per-move tile redraws and a saturating move counter. It sits between the keyboard/switch front end (go, move_valid) and the VGA drawing engines, which it enables one phase at a time. It also consumes the board checker's win/lose flags.

## Interface
Parameters:
- NUM_LEVELS, 3: number of difficulty levels; go and draw_level width; ≥1.
- DRAW_CYCLES, 3216: length in clk cycles of grid, level-banner and tile-redraw phases; ≥1.
- CLEAR_CYCLES, 16080: length in clk cycles of the screen-clear phase; ≥1.
- MOVE_W, 10: move_count width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- go  in  NUM_LEVELS  level-select / abort buttons, level-sensitive.
- move_valid  in  1  single-cycle pulse: a legal tile move was applied.
- draw_done  in  1  drawer completion pulse (used only with GAME_FLOW_DONE_HS_EN).
- win  in  1  board solved, level.
- lose  in  1  loss condition, level.
- clear  out  1  clear-screen drawer enable.
- draw_grid  out  1  grid drawer enable.
- draw_level  out  NUM_LEVELS  one-hot level-banner drawer enable.
- draw_num  out  1  tile-number redraw enable.
- in_game  out  1  game active (IN_GAME or NUM).
- game_over  out  1  end screen active.
- won  out  1  valid with game_over: 1 = win, 0 = lose.
- level  out  $clog2(NUM_LEVELS) (min 1)  latched selected level index.
- move_count  out  MOVE_W  moves this game, saturating.

## Operation
- States: CLEAR, GRID, SELECT, LEVEL, ARM, IN_GAME, NUM, OVER, ABORT_WAIT.
- Outputs are decoded from the state register: clear=CLEAR; draw_grid=GRID; draw_level=(1<<level) in LEVEL, else 0; draw_num=NUM; in_game=IN_GAME|NUM; game_over=OVER.
- A phase timer restarts at 0 on every state change. A timed phase (CLEAR, GRID, LEVEL, NUM) ends when timer==LEN-1, so the phase lasts exactly LEN cycles.
- CLEAR → GRID on expiry (CLEAR_CYCLES).
- GRID → SELECT on expiry (DRAW_CYCLES).
- SELECT: go exactly one-hot → latch level=index, clear move_count, go to LEVEL. Zero or multi-hot go → stay.
- LEVEL → ARM on expiry.
- ARM: go==0 → IN_GAME, so a held select button cannot abort.
- IN_GAME, in priority order:
  - win|lose → OVER, latching won=win (win beats lose when both are set).
  - go!=0 → ABORT_WAIT.
  - move_valid → NUM and move_count+1, saturating at all-ones.
- NUM → IN_GAME on expiry. move_valid pulses during NUM are dropped and not counted. win/lose are sampled only in IN_GAME.
- OVER: go!=0 → ABORT_WAIT.
- ABORT_WAIT: go==0 → CLEAR.
- level and won hold their values until the next SELECT latch or OVER entry.

## Timing
- Reset (async assert, sync-safe deassert):
  - state=CLEAR, timer=0, level=0, won=0, move_count=0.
  - Outputs: clear=1, all other outputs 0.
- Reset mid-phase abandons the phase immediately.
- State-to-output latency is 0 cycles, since outputs are decoded from state.
- Input-to-state latency is 1 cycle. Example: go one-hot at edge n means draw_level is asserted after edge n.
- The move_count increment and the NUM entry happen on the same edge.
- From reset release, the first SELECT is entered after CLEAR_CYCLES+DRAW_CYCLES cycles.

## Configuration
- GAME_FLOW_DONE_HS_EN defined:
  - GRID, LEVEL and NUM end on draw_done sampled high, or on timer expiry, whichever comes first. The timer acts as a watchdog.
  - CLEAR remains purely timed.
- Undefined: draw_done is ignored and all phases are purely timed.

## Structure
- Shared package game_pkg holds:
  - the state enum (typedef game_state_t);
  - the default DRAW_CYCLES/CLEAR_CYCLES localparams;
  - the one-hot-check function, which the input debouncer also uses.
- Sub-module phase_timer:
  - clear-on-state-change counter;
  - width $clog2(max(DRAW_CYCLES,CLEAR_CYCLES));
  - output expired when count==len-1, where len is selected per state.

## Test plan
- Reset, no input → clear=1 for 16080 cycles, then draw_grid=1 for 3216 cycles, then SELECT with all outputs 0.
- In SELECT, go=3'b010 held → level=1, draw_level=3'b010 for 3216 cycles. Stays in ARM until go=0, then in_game=1. go=3'b011 in SELECT causes no transition.
- In IN_GAME, three move_valid pulses spaced >3216 cycles apart → three draw_num windows of 3216 cycles, move_count=3. A pulse inside NUM is not counted. With MOVE_W=2, five moves → move_count=3.
- win=1 and lose=1 in the same cycle in IN_GAME → game_over=1, won=1, in_game=0. Then go=001, release → CLEAR, move_count retains 3 until the next select.
- go=100 in IN_GAME → ABORT_WAIT held while pressed; release → clear=1. Reset asserted mid-NUM → clear=1 immediately and move_count=0.
- With GAME_FLOW_DONE_HS_EN: draw_done pulse 10 cycles into GRID → SELECT on the next edge. With no draw_done, GRID ends at 3216 cycles.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state type, default phase lengths and one-hot check for the game sequencer.
package game_pkg;
   typedef enum logic [3:0] {
      CLEAR, GRID, SELECT, LEVEL, ARM, IN_GAME, NUM, OVER, ABORT_WAIT
   } game_state_t;
   localparam int DEFAULT_DRAW_CYCLES  = 3216;
   localparam int DEFAULT_CLEAR_CYCLES = 16080;
   function automatic logic is_one_hot(input logic [31:0] v);
      return (v != '0) && ((v & (v - 32'd1)) == '0);
   endfunction
endpackage

// File: rtl/phase_timer.sv
// phase_timer: cycle counter that restarts on every state change and flags the last cycle of a phase.
module phase_timer import game_pkg::*; #(
   parameter int DRAW_CYCLES  = DEFAULT_DRAW_CYCLES,
   parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  game_state_t state,
   output logic        expired
);
   localparam int MAX_LEN = (DRAW_CYCLES > CLEAR_CYCLES) ? DRAW_CYCLES : CLEAR_CYCLES;
   localparam int W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   logic [W-1:0] count, cur, last;
   game_state_t prev;
   // the first cycle of a new state reads as zero without waiting for a clear edge
   assign cur     = (state != prev) ? '0 : count;
   assign last    = (state == CLEAR) ? W'(CLEAR_CYCLES - 1) : W'(DRAW_CYCLES - 1);
   assign expired = cur == last;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         count <= '0;
         prev  <= CLEAR;
      end else begin
         count <= cur + 1'b1;
         prev  <= state;
      end
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: sliding-puzzle game sequencer enabling one VGA draw phase at a time.
// Optional GAME_FLOW_DONE_HS_EN lets draw_done end GRID/LEVEL/NUM early (timer becomes a watchdog).
module game_flow_ctrl import game_pkg::*; #(
   parameter int NUM_LEVELS   = 3,
   parameter int DRAW_CYCLES  = DEFAULT_DRAW_CYCLES,
   parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES,
   parameter int MOVE_W       = 10,
   localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_LEVELS-1:0] go,
   input  logic                  move_valid,
   input  logic                  draw_done,
   input  logic                  win,
   input  logic                  lose,
   output logic                  clear,
   output logic                  draw_grid,
   output logic [NUM_LEVELS-1:0] draw_level,
   output logic                  draw_num,
   output logic                  in_game,
   output logic                  game_over,
   output logic                  won,
   output logic [LW-1:0]         level,
   output logic [MOVE_W-1:0]     move_count
);
   game_state_t state;
   logic expired, done, phase_end;
   logic [LW-1:0] sel;
   phase_timer #(.DRAW_CYCLES(DRAW_CYCLES), .CLEAR_CYCLES(CLEAR_CYCLES)) u_timer (
      .clk(clk), .reset(reset), .state(state), .expired(expired)
   );
`ifdef GAME_FLOW_DONE_HS_EN
   assign done = draw_done;
`else
   assign done = 1'b0 & draw_done;
`endif
   assign phase_end = expired | done;
   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_LEVELS; i++)
         if (go[i]) sel = LW'(i);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= CLEAR;
         level      <= '0;
         won        <= 1'b0;
         move_count <= '0;
      end else begin
         case (state)
            CLEAR:      if (expired) state <= GRID;
            GRID:       if (phase_end) state <= SELECT;
            SELECT:     if (is_one_hot(32'(go))) begin
                           level      <= sel;
                           move_count <= '0;
                           state      <= LEVEL;
                        end
            LEVEL:      if (phase_end) state <= ARM;
            ARM:        if (go == '0) state <= IN_GAME;
            IN_GAME:    if (win | lose) begin
                           won   <= win;
                           state <= OVER;
                        end else if (go != '0) state <= ABORT_WAIT;
                        else if (move_valid) begin
                           move_count <= (&move_count) ? move_count : move_count + 1'b1;
                           state      <= NUM;
                        end
            NUM:        if (phase_end) state <= IN_GAME;
            OVER:       if (go != '0) state <= ABORT_WAIT;
            ABORT_WAIT: if (go == '0) state <= CLEAR;
            default:    state <= CLEAR;
         endcase
      end
   assign clear      = state == CLEAR;
   assign draw_grid  = state == GRID;
   assign draw_level = (state == LEVEL) ? NUM_LEVELS'(1) << level : '0;
   assign draw_num   = state == NUM;
   assign in_game    = (state == IN_GAME) || (state == NUM);
   assign game_over  = state == OVER;
endmodule
